// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the multi-channel TMDS/HDMI encoder:
//   tmds_mode_e           symbol mode carried alongside every input slot
//   CTRL_TOKEN            the four DVI control-period tokens, indexed by {c1,c0}
//   TERC4_LUT             HDMI TERC4 data-island symbols, indexed by nibble
//   VIDEO_GB_TOKEN        video guard-band token per guard-band set (channel mod 3)
//   DATA_GB_TOKEN_SET12   data-island guard-band token for sets 1 and 2
//   popcount8()           number of ones in a byte
// Tokens are written MSB first; bit 0 is the first bit on the wire.
// -----------------------------------------------------------------------------
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL     = 3'd0,
    MODE_VIDEO    = 3'd1,
    MODE_VIDEO_GB = 3'd2,
    MODE_DATA     = 3'd3,
    MODE_DATA_GB  = 3'd4
  } tmds_mode_e;

  localparam logic [9:0] CTRL_TOKEN [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VIDEO_GB_TOKEN [3] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

  localparam logic [9:0] DATA_GB_TOKEN_SET12 = 10'b0100110011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// -----------------------------------------------------------------------------
// tmds_channel_enc
// One TMDS lane. Stage 1 registers the transition-minimised word q_m together
// with the slot's mode/control/TERC4 fields; stage 2 produces the 10-bit symbol
// and owns the running disparity counter for this lane.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        slot at the stage-1 input is valid (loads stage 1)
//   i_mode         slot mode (5..7 behave as CTRL)
//   i_data         video byte
//   i_ctrl         control bits {c1,c0}
//   i_terc4        TERC4 nibble
//   i_s1_valid     stage-1 content is valid (updates symbol and disparity)
//   o_tmds         10-bit symbol, held across bubbles
// Parameter GB_SET selects the guard-band token set (0, 1 or 2).
// -----------------------------------------------------------------------------
module tmds_channel_enc
  import tmds_pkg::*;
#(
  parameter int GB_SET = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [2:0] i_mode,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic [3:0] i_terc4,
  input  logic       i_s1_valid,
  output logic [9:0] o_tmds
);

  localparam logic [1:0] GB_IDX = 2'(GB_SET);

  // XOR/XNOR chain; XNOR is chosen for ones-heavy bytes, q_m[8] flags XOR.
  function automatic logic [8:0] minimise_transitions(input logic [7:0] d);
    logic       use_xnor;
    logic [3:0] ones;
    logic [8:0] q;
    ones     = popcount8(d);
    use_xnor = (ones > 4'd4) || (ones == 4'd4 && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  tmds_mode_e        mode_in;
  tmds_mode_e        s1_mode;
  logic [8:0]        s1_qm;
  logic [1:0]        s1_ctrl;
  logic [3:0]        s1_terc4;
  logic              qm8;
  logic [3:0]        n1;
  logic [3:0]        n0;
  logic signed [5:0] diff;
  logic signed [5:0] cnt;
  logic signed [5:0] cnt_next;
  logic [9:0]        tmds_next;

  // Undefined mode codes collapse to CTRL before they enter the pipeline.
  always_comb begin
    mode_in = MODE_CTRL;
    if (i_mode <= 3'd4) mode_in = tmds_mode_e'(i_mode);
  end

  // Stage 1: load only on valid slots so bubbles leave nothing behind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_mode  <= MODE_CTRL;
      s1_qm    <= '0;
      s1_ctrl  <= '0;
      s1_terc4 <= '0;
    end else if (i_valid) begin
      s1_mode  <= mode_in;
      s1_qm    <= minimise_transitions(i_data);
      s1_ctrl  <= i_ctrl;
      s1_terc4 <= i_terc4;
    end
  end

  assign qm8  = s1_qm[8];
  assign n1   = popcount8(s1_qm[7:0]);
  assign n0   = 4'd8 - n1;
  assign diff = $signed({2'b00, n1}) - $signed({2'b00, n0});

  // Stage 2 symbol selection. diff is n1-n0 of q_m[7:0]; the three video
  // branches are the DVI balanced / invert-to-correct / pass-through cases.
  // Every non-video symbol returns the disparity counter to zero.
  always_comb begin
    tmds_next = CTRL_TOKEN[s1_ctrl];
    cnt_next  = '0;
    case (s1_mode)
      MODE_VIDEO: begin
        if (cnt == 6'sd0 || n1 == n0) begin
          tmds_next = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
          cnt_next  = qm8 ? cnt + diff : cnt - diff;
        end else if ((cnt > 6'sd0 && n1 > n0) || (cnt < 6'sd0 && n0 > n1)) begin
          tmds_next = {1'b1, qm8, ~s1_qm[7:0]};
          cnt_next  = cnt + (qm8 ? 6'sd2 : 6'sd0) - diff;
        end else begin
          tmds_next = {1'b0, qm8, s1_qm[7:0]};
          cnt_next  = cnt - (qm8 ? 6'sd0 : 6'sd2) + diff;
        end
      end
      MODE_VIDEO_GB: tmds_next = VIDEO_GB_TOKEN[GB_IDX];
      MODE_DATA:     tmds_next = TERC4_LUT[s1_terc4];
      MODE_DATA_GB:  tmds_next = (GB_SET == 0) ? TERC4_LUT[{2'b11, s1_ctrl}] : DATA_GB_TOKEN_SET12;
      default:       tmds_next = CTRL_TOKEN[s1_ctrl];
    endcase
  end

  // Stage 2 register: symbol and disparity advance only on valid slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tmds <= CTRL_TOKEN[0];
      cnt    <= '0;
    end else if (i_s1_valid) begin
      o_tmds <= tmds_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_multi_encoder.sv
// -----------------------------------------------------------------------------
// tmds_multi_encoder
// N-channel TMDS/HDMI encoder: CTRL, VIDEO, VIDEO_GB, DATA (TERC4) and DATA_GB
// symbols with full DVI disparity control. Fixed latency of 2 clocks, or 3 with
// REG_INPUT=1.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        input slot valid; 0 = bubble
//   i_mode         0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 DATA, 4 DATA_GB, 5-7 CTRL
//   i_data         NUM_CH video bytes, channel k at [8k+7:8k]
//   i_ctrl         NUM_CH control pairs, channel 0 = {vs,hs}
//   i_terc4        NUM_CH TERC4 nibbles
//   o_valid        o_tmds carries a new symbol set
//   o_tmds         NUM_CH 10-bit symbols, channel k at [10k+9:10k], bit 0 first
// -----------------------------------------------------------------------------
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int REG_INPUT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [2:0]           i_mode,
  input  logic [NUM_CH*8-1:0]  i_data,
  input  logic [NUM_CH*2-1:0]  i_ctrl,
  input  logic [NUM_CH*4-1:0]  i_terc4,
  output logic                 o_valid,
  output logic [NUM_CH*10-1:0] o_tmds
);

  logic                in_valid;
  logic [2:0]          in_mode;
  logic [NUM_CH*8-1:0] in_data;
  logic [NUM_CH*2-1:0] in_ctrl;
  logic [NUM_CH*4-1:0] in_terc4;
  logic                valid_s1;

  // Optional retiming register in front of the encoder pipeline.
  generate
    if (REG_INPUT != 0) begin : g_in_reg
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          in_valid <= 1'b0;
          in_mode  <= '0;
          in_data  <= '0;
          in_ctrl  <= '0;
          in_terc4 <= '0;
        end else begin
          in_valid <= i_valid;
          in_mode  <= i_mode;
          in_data  <= i_data;
          in_ctrl  <= i_ctrl;
          in_terc4 <= i_terc4;
        end
      end
    end else begin : g_in_wire
      assign in_valid = i_valid;
      assign in_mode  = i_mode;
      assign in_data  = i_data;
      assign in_ctrl  = i_ctrl;
      assign in_terc4 = i_terc4;
    end
  endgenerate

  // Valid travels beside the two encoder stages; reset flushes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_s1 <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      valid_s1 <= in_valid;
      o_valid  <= valid_s1;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      tmds_channel_enc #(.GB_SET(k % 3)) u_enc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (in_valid),
        .i_mode     (in_mode),
        .i_data     (in_data[8*k +: 8]),
        .i_ctrl     (in_ctrl[2*k +: 2]),
        .i_terc4    (in_terc4[4*k +: 4]),
        .i_s1_valid (valid_s1),
        .o_tmds     (o_tmds[10*k +: 10])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_multi_encoder
// Self-checking bench for tmds_multi_encoder: directed token/disparity cases,
// randomized mode/bubble traffic with a mid-burst reset, and a long random
// video run. Expected symbols come from a behavioural model of the DVI/HDMI
// encoding rules; video symbols are also decoded and the running disparity of
// the observed stream is tracked.
// -----------------------------------------------------------------------------
module tb_tmds_multi_encoder;

  localparam int NUM_CH    = 3;
  localparam int REG_INPUT = 0;
  localparam int LAT       = 2 + REG_INPUT;

  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] DGB12  = 10'b0100110011;
  localparam logic [9:0] CTRL_TOK [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC4_TOK [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] VGB_TOK [3] = '{10'b1011001100, 10'b0100110011, 10'b1011001100};

  logic                 clk;
  logic                 rst;
  logic                 valid;
  logic [2:0]           mode;
  logic [NUM_CH*8-1:0]  data;
  logic [NUM_CH*2-1:0]  ctrl;
  logic [NUM_CH*4-1:0]  terc4;
  logic                 o_valid;
  logic [NUM_CH*10-1:0] o_tmds;

  typedef struct {
    logic                 v;
    logic [2:0]           mode;
    logic [NUM_CH*8-1:0]  data;
    logic [NUM_CH*10-1:0] tmds;
  } exp_t;

  exp_t       sb[$];
  int         n_checks;
  int         n_fail;
  int         m_cnt  [NUM_CH];
  logic [9:0] m_last [NUM_CH];
  int         rd     [NUM_CH];

  tmds_multi_encoder #(.NUM_CH(NUM_CH), .REG_INPUT(REG_INPUT)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_mode  (mode),
    .i_data  (data),
    .i_ctrl  (ctrl),
    .i_terc4 (terc4),
    .o_valid (o_valid),
    .o_tmds  (o_tmds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM_CH*8-1:0] rand_data();
    logic [NUM_CH*8-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [NUM_CH*2-1:0] rand_ctrl();
    logic [NUM_CH*2-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[2*k +: 2] = 2'($urandom);
    return r;
  endfunction

  function automatic logic [NUM_CH*4-1:0] rand_terc4();
    logic [NUM_CH*4-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[4*k +: 4] = 4'($urandom);
    return r;
  endfunction

  // DVI video encoding of one byte given the current disparity count.
  task automatic model_video(input logic [7:0] d, input int cnt_in, output logic [9:0] sym, output int cnt_out);
    int         ones, q1, q0, b8;
    bit         use_xnor;
    logic [8:0] qm;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    b8 = int'(qm[8]);
    q1 = 0;
    for (int i = 0; i < 8; i++) q1 += int'(qm[i]);
    q0 = 8 - q1;
    if (cnt_in == 0 || q1 == q0) begin
      sym     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_out = cnt_in + (b8 == 1 ? q1 - q0 : q0 - q1);
    end else if ((cnt_in > 0 && q1 > q0) || (cnt_in < 0 && q0 > q1)) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * b8 + (q0 - q1);
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (1 - b8) + (q1 - q0);
    end
  endtask

  function automatic logic [7:0] dvi_decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic push_expect(input logic v, input logic [2:0] md, input logic [NUM_CH*8-1:0] dt,
                             input logic [NUM_CH*2-1:0] ct, input logic [NUM_CH*4-1:0] tc);
    exp_t       e;
    logic [9:0] sym;
    int         nc;
    e.v = v; e.mode = md; e.data = dt; e.tmds = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!v) begin
        sym = m_last[k];
      end else begin
        case (md)
          3'd1: begin model_video(dt[8*k +: 8], m_cnt[k], sym, nc); m_cnt[k] = nc; end
          3'd2: sym = VGB_TOK[k % 3];
          3'd3: sym = TERC4_TOK[tc[4*k +: 4]];
          3'd4: sym = (k % 3 == 0) ? TERC4_TOK[{2'b11, ct[2*k +: 2]}] : DGB12;
          default: sym = CTRL_TOK[ct[2*k +: 2]];
        endcase
        if (md != 3'd1) m_cnt[k] = 0;
      end
      m_last[k] = sym;
      e.tmds[10*k +: 10] = sym;
    end
    sb.push_back(e);
  endtask

  // Compares the slot that is due at this sample point.
  task automatic check_due();
    exp_t       e;
    logic [9:0] sym;
    int         ones;
    if (sb.size() == LAT) begin
      e = sb.pop_front();
      checkOutput("o_valid", o_valid, e.v);
      checkOutput("o_tmds", o_tmds, e.tmds);
      for (int k = 0; k < NUM_CH; k++) begin
        sym = o_tmds[10*k +: 10];
        if (e.v && e.mode == 3'd1) begin
          checkOutput("decode", dvi_decode(sym), e.data[8*k +: 8]);
          ones = 0;
          for (int i = 0; i < 10; i++) ones += int'(sym[i]);
          rd[k] += 2 * ones - 10;
          checkOutput("rd_bound", (rd[k] >= -10 && rd[k] <= 10), 1);
        end else if (e.v) begin
          rd[k] = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] md, input logic [NUM_CH*8-1:0] dt,
                               input logic [NUM_CH*2-1:0] ct, input logic [NUM_CH*4-1:0] tc);
    @(negedge clk);
    check_due();
    rst   = 1'b0;
    valid = v;
    mode  = md;
    data  = dt;
    ctrl  = ct;
    terc4 = tc;
    push_expect(v, md, dt, ct, tc);
  endtask

  task automatic flush();
    repeat (LAT) applyStimulus(1'b0, 3'($urandom_range(0, 7)), rand_data(), rand_ctrl(), rand_terc4());
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    check_due();
    rst   = 1'b1;
    valid = 1'b1;
    mode  = 3'd1;
    data  = rand_data();
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("rst_o_valid", o_valid, 1'b0);
      checkOutput("rst_o_tmds", o_tmds, {NUM_CH{CTRL00}});
    end
    sb.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k] = 0; m_last[k] = CTRL00; rd[k] = 0;
    end
    repeat (LAT) push_expect(1'b0, 3'd0, '0, '0, '0);
  endtask

  initial begin
    logic [NUM_CH*2-1:0] ct;
    logic [3:0]          nib;
    logic [2:0]          md;
    logic                v;
    rst = 1'b1; valid = 1'b0; mode = '0; data = '0; ctrl = '0; terc4 = '0;
    n_checks = 0; n_fail = 0;

    do_reset(3);

    // Idle CTRL with {vs,hs}=01 on channel 0.
    ct = rand_ctrl(); ct[1:0] = 2'b01;
    applyStimulus(1'b1, 3'd0, rand_data(), ct, rand_terc4());
    flush();
    checkOutput("ctrl01_ch0", o_tmds[9:0], 10'b0010101011);

    // Two zero bytes from cnt 0; bubbles in between must not disturb cnt.
    applyStimulus(1'b1, 3'd1, '0, rand_ctrl(), rand_terc4());
    flush();
    checkOutput("video00_first", o_tmds, {NUM_CH{10'b0100000000}});
    applyStimulus(1'b1, 3'd1, '0, rand_ctrl(), rand_terc4());
    flush();
    checkOutput("video00_second", o_tmds, {NUM_CH{10'b1111111111}});

    // 0xFF after a control slot (cnt back at 0).
    applyStimulus(1'b1, 3'd0, rand_data(), rand_ctrl(), rand_terc4());
    applyStimulus(1'b1, 3'd1, {NUM_CH{8'hFF}}, rand_ctrl(), rand_terc4());
    flush();
    checkOutput("videoFF", o_tmds, {NUM_CH{10'b1000000000}});

    applyStimulus(1'b1, 3'd2, rand_data(), rand_ctrl(), rand_terc4());
    flush();
    checkOutput("video_gb", o_tmds, {10'b1011001100, 10'b0100110011, 10'b1011001100});

    ct = rand_ctrl(); ct[1:0] = 2'b10;
    applyStimulus(1'b1, 3'd4, rand_data(), ct, rand_terc4());
    flush();
    checkOutput("data_gb", o_tmds, {10'b0100110011, 10'b0100110011, 10'b0101100011});

    // Leave cnt at -8, sweep TERC4, then video must restart from cnt 0.
    applyStimulus(1'b1, 3'd1, '0, rand_ctrl(), rand_terc4());
    for (int n = 0; n < 16; n++) begin
      nib = 4'(n);
      applyStimulus(1'b1, 3'd3, rand_data(), rand_ctrl(), {NUM_CH{nib}});
      flush();
      checkOutput($sformatf("terc4_%0d", n), o_tmds, {NUM_CH{TERC4_TOK[n]}});
    end
    applyStimulus(1'b1, 3'd1, '0, rand_ctrl(), rand_terc4());
    flush();
    checkOutput("video_after_data", o_tmds[9:0], 10'b0100000000);

    // Random modes and bubbles, reset in the middle of a video burst.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset(2);
        applyStimulus(1'b1, 3'd1, '0, rand_ctrl(), rand_terc4());
        flush();
        checkOutput("post_rst_video00", o_tmds[9:0], 10'b0100000000);
      end
      v  = ($urandom_range(0, 4) != 0);
      md = ($urandom_range(0, 9) < 6) ? 3'd1 : 3'($urandom_range(0, 7));
      if (i >= 980 && i < 1000) begin v = 1'b1; md = 3'd1; end
      applyStimulus(v, md, rand_data(), rand_ctrl(), rand_terc4());
    end

    // Long random video run.
    for (int i = 0; i < 10000; i++) applyStimulus(1'b1, 3'd1, rand_data(), rand_ctrl(), rand_terc4());
    flush();
    @(negedge clk);
    check_due();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
